// File: rtl/rvr_32_pkg.sv
// Shared constants and types for the RV32I decode stage: opcodes, ALU op
// codes, comparator op codes, immediate format select and the decoded bundle.
package rvr_32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // [1:0] class: 0 add/sub, 1 shift, 2 compare, 3 logic
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b0001;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_CMP  = 4'b0010;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1011;
  localparam logic [3:0] ALU_AND  = 4'b1111;

  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_LTU = 3'b110;
  localparam logic [2:0] CMP_GEU = 3'b111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [2:0]  cmpop;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        src1_pc;
    logic        src2_imm;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_size;
    logic [31:0] pc;
    logic        illegal;
  } idu_bundle_t;

  // ALU op for OP/OP-IMM from funct3; alt selects SUB/SRA.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:          op = alt ? ALU_SUB : ALU_ADD;
      3'b001:          op = ALU_SLL;
      3'b010, 3'b011:  op = ALU_CMP;
      3'b100:          op = ALU_XOR;
      3'b101:          op = alt ? ALU_SRA : ALU_SRL;
      3'b110:          op = ALU_OR;
      default:         op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rvr_32_idu_if.sv
// Fetch-side and execute-side handshake/bundle signals of the decode stage.
interface rvr_32_idu_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluop;
  logic [2:0]  out_cmpop;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_imm;
  logic        out_src1_pc;
  logic        out_src2_imm;
  logic        out_branch;
  logic        out_jump;
  logic        out_jalr;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic [2:0]  out_mem_size;
  logic [31:0] out_pc;
  logic        out_illegal;

  // decoder side
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_aluop, out_cmpop, out_rs1, out_rs2, out_rd,
           out_rd_we, out_imm, out_src1_pc, out_src2_imm, out_branch, out_jump,
           out_jalr, out_mem_rd, out_mem_wr, out_mem_size, out_pc, out_illegal
  );

  // fetch/execute environment side
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_aluop, out_cmpop, out_rs1, out_rs2, out_rd,
           out_rd_we, out_imm, out_src1_pc, out_src2_imm, out_branch, out_jump,
           out_jalr, out_mem_rd, out_mem_wr, out_mem_size, out_pc, out_illegal
  );

endinterface

// File: rtl/rvr_32_immgen.sv
// Combinational RV32I immediate generator; bit 31 is the sign for all formats.
module rvr_32_immgen
  import rvr_32_pkg::*;
(
  input  logic [31:7] inst_hi,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  // assemble the immediate for the selected format
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{inst_hi[31]}}, inst_hi[31:20]};
      IMM_S: imm = {{20{inst_hi[31]}}, inst_hi[31:25], inst_hi[11:7]};
      IMM_B: imm = {{19{inst_hi[31]}}, inst_hi[31], inst_hi[7], inst_hi[30:25],
                    inst_hi[11:8], 1'b0};
      IMM_U: imm = {inst_hi[31:12], 12'h000};
      IMM_J: imm = {{11{inst_hi[31]}}, inst_hi[31], inst_hi[19:12], inst_hi[20],
                    inst_hi[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rvr_32_idu.sv
// RV32I instruction decode stage: single-entry registered bundle with
// valid/ready handshake on both sides and a flush that kills the held entry.
// Optional macro RVR_32_IDU_ILLEGAL_EN: when defined, unknown opcodes and bad
// funct3/funct7 raise out_illegal; otherwise out_illegal is tied low. In both
// builds such encodings decode as a side-effect-free ADD.
module rvr_32_idu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  rvr_32_idu_if.slave bus
);

  import rvr_32_pkg::*;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  imm_fmt_t    fmt;
  logic [31:0] imm;
  idu_bundle_t d;
  idu_bundle_t q;
  logic        valid_q;
  logic        accept;
  logic        bad;
  logic        writes;

  assign opc = bus.in_inst[6:0];
  assign f3  = bus.in_inst[14:12];
  assign f7  = bus.in_inst[31:25];

  assign bus.in_ready = (~valid_q | bus.out_ready) & ~flush;
  assign accept       = bus.in_valid & bus.in_ready;

  // immediate format from opcode
  always_comb begin
    case (opc)
      OPC_LUI, OPC_AUIPC:            fmt = IMM_U;
      OPC_JAL:                       fmt = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: fmt = IMM_I;
      OPC_STORE:                     fmt = IMM_S;
      OPC_BRANCH:                    fmt = IMM_B;
      default:                       fmt = IMM_NONE;
    endcase
  end

  rvr_32_immgen u_immgen (
    .inst_hi (bus.in_inst[31:7]),
    .fmt     (fmt),
    .imm     (imm)
  );

  // decode the offered instruction into the next bundle
  always_comb begin
    d        = '0;
    bad      = 1'b0;
    writes   = 1'b0;
    d.rs1    = bus.in_inst[19:15];
    d.rs2    = bus.in_inst[24:20];
    d.rd     = bus.in_inst[11:7];
    d.imm    = imm;
    d.pc     = bus.in_pc;
    d.aluop  = ALU_ADD;
    d.cmpop  = CMP_EQ;

    case (opc)
      OPC_LUI: begin
        d.aluop    = ALU_PASS;
        d.src2_imm = 1'b1;
        writes     = 1'b1;
      end
      OPC_AUIPC: begin
        d.src1_pc  = 1'b1;
        d.src2_imm = 1'b1;
        writes     = 1'b1;
      end
      OPC_JAL: begin
        d.src1_pc  = 1'b1;
        d.src2_imm = 1'b1;
        d.jump     = 1'b1;
        writes     = 1'b1;
      end
      OPC_JALR: begin
        d.src2_imm = 1'b1;
        d.jump     = 1'b1;
        d.jalr     = 1'b1;
        writes     = 1'b1;
        bad        = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        d.branch   = 1'b1;
        d.src1_pc  = 1'b1;
        d.src2_imm = 1'b1;
        d.cmpop    = f3;
        case (f3)
          CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU: bad = 1'b0;
          default:                                          bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.mem_rd   = 1'b1;
        d.src2_imm = 1'b1;
        writes     = 1'b1;
        bad        = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        d.mem_wr   = 1'b1;
        d.src2_imm = 1'b1;
        bad        = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        d.src2_imm = 1'b1;
        writes     = 1'b1;
        d.aluop    = alu_from_funct3(f3, (f3 == 3'b101) & bus.in_inst[30]);
        if (f3 == 3'b001)
          bad = (f7 != F7_ZERO);
        else if (f3 == 3'b101)
          bad = (f7 != F7_ZERO) && (f7 != F7_ALT);
      end
      OPC_OP: begin
        writes  = 1'b1;
        d.aluop = alu_from_funct3(f3, f7 == F7_ALT);
        bad     = !((f7 == F7_ZERO) ||
                    ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      default: bad = 1'b1;
    endcase

    if ((opc == OPC_OP) || (opc == OPC_OPIMM)) begin
      if (f3 == 3'b010) d.cmpop = CMP_LT;
      if (f3 == 3'b011) d.cmpop = CMP_LTU;
    end

    // bad encodings collapse to a harmless ADD with no side effects
    if (bad) begin
      d.aluop    = ALU_ADD;
      d.cmpop    = CMP_EQ;
      d.src1_pc  = 1'b0;
      d.src2_imm = 1'b0;
      d.branch   = 1'b0;
      d.jump     = 1'b0;
      d.jalr     = 1'b0;
      d.mem_rd   = 1'b0;
      d.mem_wr   = 1'b0;
      writes     = 1'b0;
    end

    d.rd_we    = writes & (d.rd != 5'd0);
    d.mem_size = (d.mem_rd | d.mem_wr) ? f3 : 3'b000;
`ifdef RVR_32_IDU_ILLEGAL_EN
    d.illegal  = bad;
`else
    d.illegal  = 1'b0;
`endif
  end

  // stage register: flush wins, then accept, then drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      q       <= d;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_aluop    = q.aluop;
  assign bus.out_cmpop    = q.cmpop;
  assign bus.out_rs1      = q.rs1;
  assign bus.out_rs2      = q.rs2;
  assign bus.out_rd       = q.rd;
  assign bus.out_rd_we    = q.rd_we;
  assign bus.out_imm      = q.imm;
  assign bus.out_src1_pc  = q.src1_pc;
  assign bus.out_src2_imm = q.src2_imm;
  assign bus.out_branch   = q.branch;
  assign bus.out_jump     = q.jump;
  assign bus.out_jalr     = q.jalr;
  assign bus.out_mem_rd   = q.mem_rd;
  assign bus.out_mem_wr   = q.mem_wr;
  assign bus.out_mem_size = q.mem_size;
  assign bus.out_pc       = q.pc;
  assign bus.out_illegal  = q.illegal;

endmodule

// File: tb/tb_rvr_32_idu.sv
// Self-checking bench for rvr_32_idu: directed encodings, stall/flush/reset
// scenarios and a randomized run against an instruction-level reference model.
module tb_rvr_32_idu;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [2:0]  cmpop;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        src1_pc;
    logic        src2_imm;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_size;
    logic [31:0] pc;
    logic        illegal;
  } bundle_t;

  logic clk;
  logic rst_n;
  logic flush;

  rvr_32_idu_if bus ();

  rvr_32_idu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      n_chk;
  int      n_bad;
  logic    m_valid;
  bundle_t m_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] ctl(input bundle_t b);
    return {b.aluop, b.cmpop, b.rs1, b.rs2, b.rd, b.rd_we, b.src1_pc, b.src2_imm,
            b.branch, b.jump, b.jalr, b.mem_rd, b.mem_wr, b.mem_size, b.illegal};
  endfunction

  function automatic bundle_t dut_bundle();
    bundle_t b;
    b.aluop    = bus.out_aluop;
    b.cmpop    = bus.out_cmpop;
    b.rs1      = bus.out_rs1;
    b.rs2      = bus.out_rs2;
    b.rd       = bus.out_rd;
    b.rd_we    = bus.out_rd_we;
    b.imm      = bus.out_imm;
    b.src1_pc  = bus.out_src1_pc;
    b.src2_imm = bus.out_src2_imm;
    b.branch   = bus.out_branch;
    b.jump     = bus.out_jump;
    b.jalr     = bus.out_jalr;
    b.mem_rd   = bus.out_mem_rd;
    b.mem_wr   = bus.out_mem_wr;
    b.mem_size = bus.out_mem_size;
    b.pc       = bus.out_pc;
    b.illegal  = bus.out_illegal;
    return b;
  endfunction

  task automatic cmp_bundle(input string tag, input bundle_t got, input bundle_t exp);
    chk({tag, "_ctl"}, 64'(ctl(got)), 64'(ctl(exp)));
    chk({tag, "_imm"}, 64'(got.imm), 64'(exp.imm));
    chk({tag, "_pc"},  64'(got.pc),  64'(exp.pc));
  endtask

  // Reference decode written from the ISA rules, immediates by arithmetic.
  function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    bundle_t    e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    logic       wr;
    logic       is_reg;
    logic [3:0] tab [8];
    int         imm_i, imm_s, imm_b, imm_j;
    tab   = '{4'b0000, 4'b1001, 4'b0010, 4'b0010, 4'b0111, 4'b0001, 4'b1011, 4'b1111};
    f3    = i[14:12];
    f7    = i[31:25];
    imm_i = (i[31] ? -2048 : 0) + int'(i[30:20]);
    imm_s = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
    imm_b = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    imm_j = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
            + int'(i[30:21]) * 2;
    e      = '0;
    e.rs1  = i[19:15];
    e.rs2  = i[24:20];
    e.rd   = i[11:7];
    e.pc   = pc;
    legal  = 1'b1;
    wr     = 1'b0;
    is_reg = 1'b0;
    case (i[6:0])
      7'h37: begin e.aluop = 4'b0011; e.src2_imm = 1; wr = 1; e.imm = i & 32'hFFFF_F000; end
      7'h17: begin e.src1_pc = 1; e.src2_imm = 1; wr = 1; e.imm = i & 32'hFFFF_F000; end
      7'h6F: begin e.src1_pc = 1; e.src2_imm = 1; e.jump = 1; wr = 1; e.imm = 32'(imm_j); end
      7'h67: begin
        e.src2_imm = 1; e.jump = 1; e.jalr = 1; wr = 1; e.imm = 32'(imm_i);
        legal = (f3 == 3'd0);
      end
      7'h63: begin
        e.branch = 1; e.src1_pc = 1; e.src2_imm = 1; e.cmpop = f3; e.imm = 32'(imm_b);
        legal = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'h03: begin
        e.mem_rd = 1; e.src2_imm = 1; wr = 1; e.mem_size = f3; e.imm = 32'(imm_i);
        legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      7'h23: begin
        e.mem_wr = 1; e.src2_imm = 1; e.mem_size = f3; e.imm = 32'(imm_s);
        legal = (f3 <= 3'd2);
      end
      7'h13, 7'h33: begin
        is_reg  = i[5];
        e.aluop = tab[f3];
        if (f3 == 3'd0 && is_reg && f7 == 7'h20) e.aluop = 4'b0100;
        if (f3 == 3'd5 && f7[5]) e.aluop = 4'b0101;
        if (f3 == 3'd2) e.cmpop = 3'b100;
        if (f3 == 3'd3) e.cmpop = 3'b110;
        if (is_reg)
          legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (f3 == 3'd1)
          legal = (f7 == 7'h00);
        else if (f3 == 3'd5)
          legal = (f7 == 7'h00) || (f7 == 7'h20);
        e.src2_imm = !is_reg;
        wr = 1;
        if (!is_reg) e.imm = 32'(imm_i);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.aluop = '0; e.cmpop = '0; e.src1_pc = 0; e.src2_imm = 0; e.branch = 0;
      e.jump = 0; e.jalr = 0; e.mem_rd = 0; e.mem_wr = 0; e.mem_size = '0; wr = 0;
    end
    e.rd_we = wr && (e.rd != 5'd0);
`ifdef RVR_32_IDU_ILLEGAL_EN
    e.illegal = !legal;
`else
    e.illegal = 1'b0;
`endif
    return e;
  endfunction

  // One cycle: check outputs against the model, drive inputs, check in_ready,
  // advance the model across the rising edge, land on the next falling edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic exp_rdy;
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) cmp_bundle("bundle", dut_bundle(), m_b);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    exp_rdy = (!m_valid || ordy) && !fl;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (fl)
      m_valid = 1'b0;
    else if (v && exp_rdy) begin
      m_valid = 1'b1;
      m_b     = ref_decode(inst, pc);
    end else if (ordy)
      m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0]  ops [9];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    i = $urandom;
    if ($urandom_range(9) != 0) i[6:0] = ops[$urandom_range(8)];
    if ($urandom_range(3) != 0) i[31:25] = ($urandom_range(1) != 0) ? 7'h20 : 7'h00;
    return i;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    n_chk   = 0;
    n_bad   = 0;
    m_valid = 1'b0;
    m_b     = '0;
    pc      = 32'h0000_1000;
    rst_n   = 1'b0;
    flush   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    cmp_bundle("reset", dut_bundle(), bundle_t'('0));
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    flush = 1'b1;
    #1;
    chk("reset_in_ready_flush", 64'(bus.in_ready), 64'd0);
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3,x1,x2
    step(1, 32'h0020_81B3, pc, 1, 0); pc += 4;
    chk("add_valid", 64'(bus.out_valid), 64'd1);
    chk("add_aluop", 64'(bus.out_aluop), 64'h0);
    chk("add_rs1",   64'(bus.out_rs1),   64'd1);
    chk("add_rs2",   64'(bus.out_rs2),   64'd2);
    chk("add_rd",    64'(bus.out_rd),    64'd3);
    chk("add_rd_we", 64'(bus.out_rd_we), 64'd1);

    // SRAI x5,x6,3
    step(1, 32'h4033_5293, pc, 1, 0); pc += 4;
    chk("srai_aluop", 64'(bus.out_aluop),    64'h5);
    chk("srai_src2",  64'(bus.out_src2_imm), 64'd1);
    chk("srai_imm",   64'(bus.out_imm),      64'h0000_0403);
    chk("srai_rd",    64'(bus.out_rd),       64'd5);

    // LUI x7,0x12345 and LUI x0,0x12345
    step(1, 32'h1234_53B7, pc, 1, 0); pc += 4;
    chk("lui_aluop", 64'(bus.out_aluop), 64'h3);
    chk("lui_imm",   64'(bus.out_imm),   64'h1234_5000);
    chk("lui_rd_we", 64'(bus.out_rd_we), 64'd1);
    step(1, 32'h1234_5037, pc, 1, 0); pc += 4;
    chk("lui_x0_rd_we", 64'(bus.out_rd_we), 64'd0);

    // BLT x1,x2,-8
    step(1, 32'hFE20_CCE3, pc, 1, 0); pc += 4;
    chk("blt_branch", 64'(bus.out_branch),  64'd1);
    chk("blt_cmpop",  64'(bus.out_cmpop),   64'h4);
    chk("blt_imm",    64'(bus.out_imm),     64'hFFFF_FFF8);
    chk("blt_rd_we",  64'(bus.out_rd_we),   64'd0);
    chk("blt_src1",   64'(bus.out_src1_pc), 64'd1);

    // back-pressure for 5 cycles with a new instruction waiting
    pc_a = pc; pc += 4;
    pc_b = pc; pc += 4;
    step(1, 32'h0020_81B3, pc_a, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 32'h4033_5293, pc_b, 0, 0);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_pc", 64'(bus.out_pc), 64'(pc_a));
    end
    step(1, 32'h4033_5293, pc_b, 1, 0);
    chk("stall_next_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_next_pc", 64'(bus.out_pc), 64'(pc_b));
    step(0, 32'h0, 32'h0, 1, 0);
    chk("stall_no_dup", 64'(bus.out_valid), 64'd0);

    // flush while held and stalled
    step(1, 32'h1234_53B7, pc, 1, 0); pc += 4;
    step(1, 32'h0020_81B3, pc, 0, 1);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);

    // opcode 0x7F
    step(1, 32'h0000_007F, pc, 1, 0); pc += 4;
`ifdef RVR_32_IDU_ILLEGAL_EN
    chk("illegal_flag", 64'(bus.out_illegal), 64'd1);
`else
    chk("illegal_flag", 64'(bus.out_illegal), 64'd0);
`endif
    chk("illegal_rd_we", 64'(bus.out_rd_we), 64'd0);

    // asynchronous reset in the middle of a stall
    step(1, 32'h0020_81B3, pc, 1, 0); pc += 4;
    step(1, 32'h0000_0013, pc, 0, 0);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_stall_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_stall_in_ready", 64'(bus.in_ready), 64'd1);
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic v, r, f;
      v = ($urandom_range(9) < 7);
      r = ($urandom_range(9) < 6);
      f = ($urandom_range(15) == 0);
      step(v, rand_inst(), pc, r, f);
      if (v) pc += 4;
    end
    step(0, 32'h0, 32'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rvr_32_idu.md
RVR_32_IDU -- requirements
Module: rvr_32_idu

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 flush  input  1  kill decode-stage contents (branch/trap redirect).
REQ-005 in_valid  input  1  fetch offers instruction.
REQ-006 in_ready  output  1  decoder accepts this cycle.
REQ-007 in_inst  input  32  RV32I instruction word.
REQ-008 in_pc  input  32  instruction address.
REQ-009 out_valid  output  1  decoded bundle valid.
REQ-010 out_ready  input  1  execute stage accepts bundle.
REQ-011 out_aluop  output  4  ALU op code: [1:0] class (0 add/sub, 1 shift, 2 compare, 3 logic); add: [2]=sub; shift: [3]=left, [2]=arithmetic; logic: [3:2] 0 pass-op2, 1 xor, 2 or, 3 and.
REQ-012 out_cmpop  output  3  comparator op: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
REQ-013 out_rs1, out_rs2, out_rd  output  5 each  register indices.
REQ-014 out_rd_we  output  1  register writeback enable.
REQ-015 out_imm  output  32  sign-extended immediate.
REQ-016 out_src1_pc / out_src2_imm  output  1 each  ALU operand selects (pc for op1, imm for op2).
REQ-017 out_branch, out_jump, out_jalr, out_mem_rd, out_mem_wr  output  1 each  control flags.
REQ-018 out_mem_size  output  3  funct3 of load/store.
REQ-019 out_pc  output  32  registered in_pc.
REQ-020 out_illegal  output  1  illegal-instruction flag.

Function
REQ-021 Single-entry registered stage; latency exactly one cycle from accept to out_valid.
REQ-022 in_ready SHALL equal (!out_valid | out_ready) & !flush.
REQ-023 Accept (in_valid & in_ready) loads all outputs and sets out_valid next cycle.
REQ-024 out_valid & out_ready without accept SHALL clear out_valid next cycle.
REQ-025 While out_valid & !out_ready, all outputs SHALL hold stable.
REQ-026 flush SHALL clear out_valid next cycle regardless of other inputs; nothing accepted that cycle.
REQ-027 Decode: OP/OP-IMM -> ADD 0000, SUB 0100, SLL 1001, SRL 0001, SRA 0101, XOR 0111, OR 1011, AND 1111, SLT/SLTU aluop 0010 with cmpop 100/110.
REQ-028 LUI -> aluop 0011, src2_imm; AUIPC/JAL/JALR/loads/stores -> aluop 0000 (add); branches -> cmpop=funct3, branch=1, aluop 0000, src1_pc, src2_imm.
REQ-029 Immediates per I/S/B/U/J formats, bit 31 sign-extended; U-type low 12 bits zero.
REQ-030 out_rd_we SHALL be 0 when rd==0, and for branches, stores, illegal.
REQ-031 SUB/SRA selected only when funct7==0100000; SRAI by inst[30].

Reset
REQ-032 While rst_n low: out_valid=0, all other outputs 0; in_ready follows REQ-022 (1 unless flush).
REQ-033 Reset mid-handshake discards the held bundle; no replay.

Configuration
REQ-034 Macro RVR_32_IDU_ILLEGAL_EN: defined -> unknown opcode, bad funct3/funct7 set out_illegal=1 and force rd_we, mem_rd, mem_wr, branch, jump to 0; undefined -> out_illegal tied 0, unknown encodings decode as ADD with rd_we=0.

Structure
REQ-035 Shared package rvr_32_pkg SHALL hold opcode constants, aluop constants, cmpop constants.
REQ-036 Combinational immediate generator as sub-module rvr_32_immgen; stage register in rvr_32_idu.

Verification
REQ-037 0x002081B3 (ADD x3,x1,x2) -> aluop 0000, rs1 1, rs2 2, rd 3, rd_we 1, one cycle later.
REQ-038 0x40335293 (SRAI x5,x6,3) -> aluop 0101, src2_imm 1, imm 0x00000403, rd 5.
REQ-039 0x123453B7 (LUI x7,0x12345) -> aluop 0011, imm 0x12345000, rd_we 1; same with rd=0 -> rd_we 0.
REQ-040 BLT x1,x2,-8 -> branch 1, cmpop 100, imm 0xFFFFFFF8, rd_we 0, src1_pc 1.
REQ-041 out_ready low 5 cycles with in_valid high -> outputs stable, in_ready 0; out_ready high -> next bundle one cycle later, none lost or duplicated.
REQ-042 flush while out_valid & !out_ready -> out_valid 0 next cycle; rst_n low mid-stall -> out_valid 0 immediately; opcode 0x7F with RVR_32_IDU_ILLEGAL_EN -> out_illegal 1.
